bram_fifo_ctl: RTL and testbench

- Synchronous FIFO controller that owns both ports of an external dual-ported 4kb block RAM: write-enable/address/data and read-enable/address/data.
- It is the stage directly upstream of that RAM. It turns a valid/ready producer stream into RAM writes, and turns RAM reads into a registered valid/ready consumer stream.
- The RAM commits writes on posedge i_clk and captures reads on negedge i_clk. Its read data is forced to 0 in any cycle where read-enable is low.

---
 rtl/bram_fifo_ctl_pkg.sv | 14 +
 rtl/bram_fifo_ctl.sv | 84 ++++++++
 tb/tb_bram_fifo_ctl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctl_pkg.sv
// Shared sizing for the block-RAM FIFO controller.
// Defaults match a 4kb dual-ported RAM (16 x 256).
package bram_fifo_ctl_pkg;

  localparam int DEF_DATA_SZ = 16;
  localparam int DEF_ADDR_SZ = 8;
  localparam int BRAM_BITS   = 4096;

  // True when a data/depth pair exactly fills one RAM block.
  function automatic bit bram_fits(int data_sz, int mem_max);
    return (data_sz * mem_max) == BRAM_BITS;
  endfunction

endpackage

// File: rtl/bram_fifo_ctl.sv
// FIFO controller owning both ports of a negedge-read block RAM.
// Ports: i_clk, i_rst (sync, high); producer i_valid/o_ready/i_data;
//   consumer o_valid/i_ready/o_data; o_count = RAM words + o_valid;
//   RAM write o_wr_en/o_waddr/o_wdata; RAM read o_rd_en/o_raddr/i_rdata.
module bram_fifo_ctl
  import bram_fifo_ctl_pkg::*;
#(
  parameter int DATA_SZ = DEF_DATA_SZ,
  parameter int ADDR_SZ = DEF_ADDR_SZ,
  parameter int MEM_MAX = 1 << ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_SZ-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_SZ-1:0] o_data,
  output logic [ADDR_SZ:0]   o_count,
  output logic               o_wr_en,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd_en,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata
);

  if (MEM_MAX != (1 << ADDR_SZ)) begin : g_bad_depth
    $error("MEM_MAX must equal 1<<ADDR_SZ");
  end

  localparam logic [ADDR_SZ:0] FULL = (ADDR_SZ+1)'(MEM_MAX);

  logic [ADDR_SZ-1:0] wr_ptr;
  logic [ADDR_SZ-1:0] rd_ptr;
  logic [ADDR_SZ:0]   mem_cnt;
  logic               push;
  logic               fetch;
  logic               pop;

  // Ready looks only at registered state: no pop-to-push bypass.
  assign o_ready = (mem_cnt != FULL) && !i_rst;
  assign push    = i_valid && o_ready;

  // Must settle before the RAM's negedge capture; keep it shallow.
  assign fetch = (mem_cnt != '0) && (!o_valid || i_ready) && !i_rst;
  assign pop   = o_valid && i_ready;

  assign o_wr_en = push;
  assign o_waddr = wr_ptr;
  assign o_wdata = i_data;
  assign o_rd_en = fetch;
  assign o_raddr = rd_ptr;

  assign o_count = mem_cnt + {{ADDR_SZ{1'b0}}, o_valid};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_SZ'(1);
      // RAM data is only meaningful after a fetch; it reads 0 otherwise.
      if (fetch) begin
        rd_ptr  <= rd_ptr + ADDR_SZ'(1);
        o_data  <= i_rdata;
        o_valid <= 1'b1;
      end else if (pop) begin
        o_valid <= 1'b0;
      end
      case ({push, fetch})
        2'b10:   mem_cnt <= mem_cnt + (ADDR_SZ+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (ADDR_SZ+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctl.sv
// Directed bench: two controllers (depth 256 and depth 4),
// each paired with a negedge-read RAM model.
module tb_bram_fifo_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass = 0;
  int total = 0;

  // DUT a: default sizing
  logic        a_valid, a_ready, a_ovalid, a_iready;
  logic [15:0] a_data, a_odata, a_wdata, a_rdata;
  logic [8:0]  a_count;
  logic        a_wr_en, a_rd_en;
  logic [7:0]  a_waddr, a_raddr;
  logic [15:0] mem_a [256];

  bram_fifo_ctl dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_valid(a_valid), .o_ready(a_ready), .i_data(a_data),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata),
    .o_count(a_count),
    .o_wr_en(a_wr_en), .o_waddr(a_waddr), .o_wdata(a_wdata),
    .o_rd_en(a_rd_en), .o_raddr(a_raddr), .i_rdata(a_rdata)
  );

  always @(posedge clk) if (a_wr_en) mem_a[a_waddr] <= a_wdata;
  always @(negedge clk) a_rdata <= a_rd_en ? mem_a[a_raddr] : 16'h0;

  // DUT b: depth 4
  logic        b_valid, b_ready, b_ovalid, b_iready;
  logic [15:0] b_data, b_odata, b_wdata, b_rdata;
  logic [2:0]  b_count;
  logic        b_wr_en, b_rd_en;
  logic [1:0]  b_waddr, b_raddr;
  logic [15:0] mem_b [4];

  bram_fifo_ctl #(.DATA_SZ(16), .ADDR_SZ(2), .MEM_MAX(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_valid(b_valid), .o_ready(b_ready), .i_data(b_data),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata),
    .o_count(b_count),
    .o_wr_en(b_wr_en), .o_waddr(b_waddr), .o_wdata(b_wdata),
    .o_rd_en(b_rd_en), .o_raddr(b_raddr), .i_rdata(b_rdata)
  );

  always @(posedge clk) if (b_wr_en) mem_b[b_waddr] <= b_wdata;
  always @(negedge clk) b_rdata <= b_rd_en ? mem_b[b_raddr] : 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_iready = 1'b1; a_data = 16'hFFFF;
    #1;
    total++;
    if (a_wr_en !== 1'b0 || a_rd_en !== 1'b0 || a_ready !== 1'b0)
      $display("FAIL rst_comb wr=%b rd=%b rdy=%b want 0 0 0",
               a_wr_en, a_rd_en, a_ready);
    else pass++;
    tick();
    rst = 1'b0; a_valid = 1'b0; a_iready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (a_ovalid !== 1'b0 || a_count !== 9'd0 || a_ready !== 1'b1 ||
          a_rd_en !== 1'b0 || a_wr_en !== 1'b0 || a_odata !== 16'h0)
        $display("FAIL idle c%0d v=%b cnt=%0d rdy=%b rd=%b wr=%b d=%h",
                 c, a_ovalid, a_count, a_ready, a_rd_en, a_wr_en, a_odata);
      else pass++;
      tick();
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_data = 16'hA5A5; a_iready = 1'b0;
    #1;
    total++;
    if (a_wr_en !== 1'b1 || a_waddr !== 8'd0)
      $display("FAIL single_wr wr=%b addr=%0d want 1 0", a_wr_en, a_waddr);
    else pass++;
    tick();
    a_valid = 1'b0;
    #1;
    total++;
    if (a_rd_en !== 1'b1 || a_raddr !== 8'd0 || a_ovalid !== 1'b0)
      $display("FAIL single_fetch rd=%b addr=%0d v=%b want 1 0 0",
               a_rd_en, a_raddr, a_ovalid);
    else pass++;
    tick();
    for (int c = 2; c < 5; c++) begin
      #1;
      total++;
      if (a_ovalid !== 1'b1 || a_odata !== 16'hA5A5 ||
          a_count !== 9'd1 || a_rd_en !== 1'b0)
        $display("FAIL single_hold c%0d v=%b d=%h cnt=%0d rd=%b want 1 a5a5 1 0",
                 c, a_ovalid, a_odata, a_count, a_rd_en);
      else pass++;
      tick();
    end
    a_iready = 1'b1;
    tick();
    total++;
    if (a_ovalid !== 1'b0 || a_count !== 9'd0)
      $display("FAIL single_pop v=%b cnt=%0d want 0 0", a_ovalid, a_count);
    else pass++;
    a_iready = 1'b0;
  endtask

  task automatic test_stream();
    a_iready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      a_valid = (c < 10);
      a_data = 16'(c + 1);
      #1;
      total++;
      if (c >= 2 && c <= 11) begin
        if (a_ovalid !== 1'b1 || a_odata !== 16'(c - 1))
          $display("FAIL stream_out c%0d v=%b d=%0d want 1 %0d",
                   c, a_ovalid, a_odata, c - 1);
        else pass++;
      end else begin
        if (a_ovalid !== 1'b0)
          $display("FAIL stream_idle c%0d v=%b want 0", c, a_ovalid);
        else pass++;
      end
      total++;
      if (a_count > 9'd2)
        $display("FAIL stream_cnt c%0d cnt=%0d want <=2", c, a_count);
      else pass++;
      tick();
    end
    a_valid = 1'b0; a_iready = 1'b0;
  endtask

  task automatic test_fill();
    b_iready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      b_valid = 1'b1; b_data = 16'(c + 1);
      #1;
      total++;
      if (b_ready !== 1'b1)
        $display("FAIL fill_rdy c%0d rdy=%b want 1", c, b_ready);
      else pass++;
      tick();
    end
    b_data = 16'h0066;
    #1;
    total++;
    if (b_count !== 3'd5 || b_ready !== 1'b0 || b_wr_en !== 1'b0)
      $display("FAIL fill_full cnt=%0d rdy=%b wr=%b want 5 0 0",
               b_count, b_ready, b_wr_en);
    else pass++;
    tick();
    b_valid = 1'b0;
    #1;
    total++;
    if (b_count !== 3'd5)
      $display("FAIL fill_ignore cnt=%0d want 5", b_count);
    else pass++;
    b_iready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      total++;
      if (b_ovalid !== 1'b1 || b_odata !== 16'(k))
        $display("FAIL fill_drain k%0d v=%b d=%0d want 1 %0d",
                 k, b_ovalid, b_odata, k);
      else pass++;
      tick();
    end
    total++;
    if (b_ovalid !== 1'b0 || b_count !== 3'd0)
      $display("FAIL fill_empty v=%b cnt=%0d want 0 0", b_ovalid, b_count);
    else pass++;
    b_iready = 1'b0;
  endtask

  task automatic test_full_stream();
    int nxt_in;
    int exp_out;
    b_iready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      b_valid = 1'b1; b_data = 16'(c + 1);
      tick();
    end
    nxt_in = 6;
    exp_out = 1;
    b_iready = 1'b1;
    // First cycle from full only pops; afterwards push and pop pair up.
    for (int c = 0; c < 20; c++) begin
      b_valid = 1'b1; b_data = 16'(nxt_in);
      #1;
      total++;
      if (b_ready !== (c != 0))
        $display("FAIL fs_rdy c%0d rdy=%b want %0b", c, b_ready, c != 0);
      else pass++;
      total++;
      if (b_ovalid !== 1'b1 || b_odata !== 16'(exp_out))
        $display("FAIL fs_out c%0d v=%b d=%0d want 1 %0d",
                 c, b_ovalid, b_odata, exp_out);
      else pass++;
      if (c >= 1) begin
        total++;
        if (b_count !== 3'd4)
          $display("FAIL fs_cnt c%0d cnt=%0d want 4", c, b_count);
        else pass++;
      end
      if (c != 0) nxt_in++;
      exp_out++;
      tick();
    end
    b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (b_ovalid !== 1'b1 || b_odata !== 16'(exp_out))
        $display("FAIL fs_drain k%0d v=%b d=%0d want 1 %0d",
                 k, b_ovalid, b_odata, exp_out);
      else pass++;
      exp_out++;
      tick();
    end
    total++;
    if (b_ovalid !== 1'b0 || b_count !== 3'd0)
      $display("FAIL fs_empty v=%b cnt=%0d want 0 0", b_ovalid, b_count);
    else pass++;
    b_iready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_iready = 1'b0;
    a_valid = 1'b1; a_data = 16'h0011; tick();
    a_data = 16'h0022; tick();
    a_data = 16'h0033; tick();
    a_valid = 1'b0;
    #1;
    total++;
    if (a_count !== 9'd3)
      $display("FAIL mid_queued cnt=%0d want 3", a_count);
    else pass++;
    rst = 1'b1; a_iready = 1'b1;
    #1;
    total++;
    if (a_rd_en !== 1'b0 || a_wr_en !== 1'b0)
      $display("FAIL mid_rst_comb rd=%b wr=%b want 0 0", a_rd_en, a_wr_en);
    else pass++;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (a_ovalid !== 1'b0 || a_count !== 9'd0)
      $display("FAIL mid_cleared v=%b cnt=%0d want 0 0", a_ovalid, a_count);
    else pass++;
    a_valid = 1'b1; a_data = 16'h0042;
    tick();
    a_valid = 1'b0;
    tick();
    total++;
    if (a_ovalid !== 1'b1 || a_odata !== 16'h0042)
      $display("FAIL mid_first v=%b d=%h want 1 0042", a_ovalid, a_odata);
    else pass++;
    tick();
    total++;
    if (a_ovalid !== 1'b0 || a_count !== 9'd0)
      $display("FAIL mid_after v=%b cnt=%0d want 0 0", a_ovalid, a_count);
    else pass++;
  endtask

  initial begin
    a_valid = 1'b0; a_iready = 1'b0; a_data = 16'h0; a_rdata = 16'h0;
    b_valid = 1'b0; b_iready = 1'b0; b_data = 16'h0; b_rdata = 16'h0;
    tick();
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_full_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
